// File: rtl/dsp_mac_pe.sv
// dsp_mac_pe: pipelined MAC processing element for the systolic array.
// Three register stages (operand capture, product, add/accumulate) behind a
// valid/ready handshake. Output back-pressure freezes the whole pipe.
// Ops: ADD, MUL, MAC (first/last framed accumulation into an internal acc).
// Optional build macro DSP_MAC_PE_SAT_EN: clamp to the ACCUM_BIT range
// instead of wrapping; a clamped accumulator holds until the next first=1.
module dsp_mac_pe #(
    parameter int ACT_BIT    = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int ACCUM_BIT  = 32,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic                  first,
    input  logic                  last,
    input  logic [ACT_BIT-1:0]    act,
    input  logic [WEIGHT_BIT-1:0] wgt,
    input  logic [ACCUM_BIT-1:0]  addend,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCUM_BIT-1:0]  out_data,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int         PW     = ACT_BIT + WEIGHT_BIT;
    localparam int         MSB    = ACCUM_BIT - 1;
    localparam bit         SGN    = (SIGNED != 0);
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
`ifdef DSP_MAC_PE_SAT_EN
    localparam logic [ACCUM_BIT-1:0] U_MAX = '1;
    localparam logic [ACCUM_BIT-1:0] S_MAX = {1'b0, {(ACCUM_BIT-1){1'b1}}};
    localparam logic [ACCUM_BIT-1:0] S_MIN = {1'b1, {(ACCUM_BIT-1){1'b0}}};
`endif

    typedef struct packed {
        logic [1:0]            op;
        logic                  first;
        logic                  last;
        logic [ACT_BIT-1:0]    act;
        logic [WEIGHT_BIT-1:0] wgt;
        logic [ACCUM_BIT-1:0]  addend;
    } s1_t;

    typedef struct packed {
        logic [1:0]           op;
        logic                 first;
        logic                 last;
        logic [ACCUM_BIT-1:0] act_x;
        logic [ACCUM_BIT-1:0] addend;
        logic [ACCUM_BIT-1:0] prod;
    } s2_t;

    // vld_pipe[1] = S1 holds a beat, vld_pipe[2] = S2 holds a beat
    logic [2:1]           vld_pipe_d, vld_pipe_q;
    s1_t                  s1_d, s1_q;
    s2_t                  s2_d, s2_q;
    logic                 out_vld_d, out_vld_q;
    logic [ACCUM_BIT-1:0] out_data_d, out_data_q;
    logic                 out_ovf_d, out_ovf_q;
    logic [ACCUM_BIT-1:0] acc_d, acc_q;
    logic                 acc_ovf_d, acc_ovf_q;
    logic                 seq_open_d, seq_open_q;

    logic                 adv, in_fire;
    logic [PW-1:0]        act_w, wgt_w, prod_w;
    logic                 is_mac, is_mul;
    logic [ACCUM_BIT-1:0] op_a, op_b, sum, res;
    logic [ACCUM_BIT:0]   sum_w;
    logic                 ovf, mac_ovf;

    // a held output stalls every stage, so nothing can be lost or duplicated
    assign adv       = !(out_vld_q && !out_ready);
    assign in_ready  = adv;
    assign in_fire   = in_valid && adv;
    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (|vld_pipe_q) || out_vld_q || seq_open_q;

    // S1 capture and S2 product; the narrow PW-wide multiply maps onto the DSP
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        act_w      = {{WEIGHT_BIT{SGN & s1_q.act[ACT_BIT-1]}}, s1_q.act};
        wgt_w      = {{ACT_BIT{SGN & s1_q.wgt[WEIGHT_BIT-1]}}, s1_q.wgt};
        prod_w     = act_w * wgt_w;
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[1], in_fire};
            if (in_fire) begin
                s1_d = '{op: op, first: first, last: last, act: act, wgt: wgt, addend: addend};
            end
            if (vld_pipe_q[1]) begin
                s2_d.op     = s1_q.op;
                s2_d.first  = s1_q.first;
                s2_d.last   = s1_q.last;
                s2_d.addend = s1_q.addend;
                s2_d.act_x  = {{(ACCUM_BIT-ACT_BIT){SGN & s1_q.act[ACT_BIT-1]}}, s1_q.act};
                s2_d.prod   = {{(ACCUM_BIT-PW){SGN & prod_w[PW-1]}}, prod_w};
            end
        end
    end

    // S3: one shared adder serves ADD, MUL (0 + prod) and MAC (base + prod)
    always_comb begin
        is_mac     = (s2_q.op == OP_MAC);
        is_mul     = (s2_q.op == OP_MUL);
        op_a       = is_mul ? '0 : (is_mac ? (s2_q.first ? s2_q.addend : acc_q) : s2_q.addend);
        op_b       = (is_mul || is_mac) ? s2_q.prod : s2_q.act_x;
        sum_w      = {1'b0, op_a} + {1'b0, op_b};
        sum        = sum_w[ACCUM_BIT-1:0];
        ovf        = SGN ? ((op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB])) : sum_w[ACCUM_BIT];
        mac_ovf    = (s2_q.first ? 1'b0 : acc_ovf_q) | ovf;
        res        = sum;
`ifdef DSP_MAC_PE_SAT_EN
        if (ovf) res = SGN ? (op_a[MSB] ? S_MIN : S_MAX) : U_MAX;
        // a clamped accumulator stays pinned until the sequence restarts
        if (is_mac && !s2_q.first && acc_ovf_q) res = acc_q;
`endif
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;
        seq_open_d = seq_open_q;
        if (adv) begin
            out_vld_d = vld_pipe_q[2] && (!is_mac || s2_q.last);
            if (vld_pipe_q[2]) begin
                if (is_mac) begin
                    acc_d      = res;
                    acc_ovf_d  = mac_ovf;
                    seq_open_d = !s2_q.last;
                end
                if (!is_mac || s2_q.last) begin
                    out_data_d = res;
                    out_ovf_d  = is_mac ? mac_ovf : ovf;
                end
            end
        end
    end

    // state registers; reset abandons anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
            seq_open_q <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            acc_q      <= acc_d;
            acc_ovf_q  <= acc_ovf_d;
            seq_open_q <= seq_open_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac_pe.sv
// Directed bench for dsp_mac_pe: an unsigned instance (8x8 -> 17-bit acc, so
// overflow is easy to reach) and a signed instance (8x8 -> 32-bit acc).
module tb_dsp_mac_pe;

`ifdef DSP_MAC_PE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int UA = 17;
    localparam int SA = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // unsigned instance
    logic          u_in_valid = 0, u_in_ready, u_first = 0, u_last = 0;
    logic [1:0]    u_op = 0;
    logic [7:0]    u_act = 0, u_wgt = 0;
    logic [UA-1:0] u_addend = 0, u_out_data;
    logic          u_out_valid, u_out_ready = 1, u_out_ovf, u_busy;
    // signed instance
    logic          s_in_valid = 0, s_in_ready, s_first = 0, s_last = 0;
    logic [1:0]    s_op = 0;
    logic [7:0]    s_act = 0, s_wgt = 0;
    logic [SA-1:0] s_addend = 0, s_out_data;
    logic          s_out_valid, s_out_ready = 1, s_out_ovf, s_busy;

    dsp_mac_pe #(.ACT_BIT(8), .WEIGHT_BIT(8), .ACCUM_BIT(UA), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .op(u_op), .first(u_first), .last(u_last), .act(u_act), .wgt(u_wgt),
        .addend(u_addend), .out_valid(u_out_valid), .out_ready(u_out_ready),
        .out_data(u_out_data), .out_ovf(u_out_ovf), .busy(u_busy));

    dsp_mac_pe #(.ACT_BIT(8), .WEIGHT_BIT(8), .ACCUM_BIT(SA), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .first(s_first), .last(s_last), .act(s_act), .wgt(s_wgt),
        .addend(s_addend), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .busy(s_busy));

    int n_chk = 0;
    int n_pass = 0;

    logic [UA-1:0] uq_d[$];
    logic          uq_o[$];
    logic [SA-1:0] sq_d[$];
    logic          sq_o[$];

    // collect every consumed result, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && u_out_valid && u_out_ready) begin
            uq_d.push_back(u_out_data);
            uq_o.push_back(u_out_ovf);
        end
        if (rst_n && s_out_valid && s_out_ready) begin
            sq_d.push_back(s_out_data);
            sq_o.push_back(s_out_ovf);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic u_beat(input logic [1:0] o, input logic f, input logic l,
                          input logic [7:0] a, input logic [7:0] w, input logic [UA-1:0] ad);
        u_op = o; u_first = f; u_last = l; u_act = a; u_wgt = w; u_addend = ad;
        u_in_valid = 1'b1;
        step();
        u_in_valid = 1'b0;
    endtask

    task automatic s_beat(input logic [1:0] o, input logic f, input logic l,
                          input logic [7:0] a, input logic [7:0] w, input logic [SA-1:0] ad);
        s_op = o; s_first = f; s_last = l; s_act = a; s_wgt = w; s_addend = ad;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
    endtask

    function automatic logic [UA-1:0] uq_at(input int k);
        return (k < uq_d.size()) ? uq_d[k] : 'x;
    endfunction
    function automatic logic uo_at(input int k);
        return (k < uq_o.size()) ? uq_o[k] : 1'bx;
    endfunction
    function automatic logic [SA-1:0] sq_at(input int k);
        return (k < sq_d.size()) ? sq_d[k] : 'x;
    endfunction
    function automatic logic so_at(input int k);
        return (k < sq_o.size()) ? sq_o[k] : 1'bx;
    endfunction

    typedef struct {
        logic [1:0]    op;
        logic          first, last;
        logic [7:0]    act, wgt;
        logic [UA-1:0] addend;
        logic          exp_v;
        logic [UA-1:0] exp_d;
        logic          exp_o;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [UA-1:0] held;
        logic [SA-1:0] e32;
        int i, stall_bad;
        bit saw_stall;

        vecs[0]  = '{2'b00, 0, 0, 8'd23,  8'd0,   17'd100,    1, 17'd123,   0};
        vecs[1]  = '{2'b01, 0, 0, 8'd200, 8'd250, 17'd0,      1, 17'd50000, 0};
        vecs[2]  = '{2'b01, 0, 0, 8'd255, 8'd255, 17'd0,      1, 17'd65025, 0};
        vecs[3]  = '{2'b00, 0, 0, 8'd1,   8'd0,   17'd131071, 1, SAT_EN ? 17'd131071 : 17'd0, 1};
        vecs[4]  = '{2'b11, 0, 0, 8'd7,   8'd0,   17'd5,      1, 17'd12,    0};
        vecs[5]  = '{2'b00, 1, 0, 8'd1,   8'd0,   17'd1,      1, 17'd2,     0};
        vecs[6]  = '{2'b01, 1, 1, 8'd9,   8'd9,   17'd1000,   1, 17'd81,    0};
        vecs[7]  = '{2'b10, 1, 1, 8'd3,   8'd4,   17'd10,     1, 17'd22,    0};
        vecs[8]  = '{2'b10, 1, 0, 8'd5,   8'd5,   17'd0,      0, 17'd0,     0};
        vecs[9]  = '{2'b10, 0, 1, 8'd1,   8'd1,   17'd999,    1, 17'd26,    0};
        vecs[10] = '{2'b00, 0, 0, 8'd71,  8'd0,   17'd131000, 1, 17'd131071, 0};

        // reset state
        repeat (2) step();
        chk("rst_u_valid", u_out_valid, 0);
        chk("rst_u_data", u_out_data, 0);
        chk("rst_u_ovf", u_out_ovf, 0);
        chk("rst_u_ready", u_in_ready, 1);
        chk("rst_u_busy", u_busy, 0);
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_busy", s_busy, 0);
        rst_n = 1'b1;
        step();

        // single-beat vectors: output exactly three cycles after presentation
        for (int k = 0; k < 11; k++) begin
            u_beat(vecs[k].op, vecs[k].first, vecs[k].last, vecs[k].act, vecs[k].wgt, vecs[k].addend);
            chk($sformatf("v%0d_lat1", k), u_out_valid, 0);
            step();
            chk($sformatf("v%0d_lat2", k), u_out_valid, 0);
            step();
            chk($sformatf("v%0d_valid", k), u_out_valid, vecs[k].exp_v);
            if (vecs[k].exp_v) begin
                chk($sformatf("v%0d_data", k), u_out_data, vecs[k].exp_d);
                chk($sformatf("v%0d_ovf", k), u_out_ovf, vecs[k].exp_o);
            end else begin
                chk($sformatf("v%0d_busy_open", k), u_busy, 1);
            end
        end
        step();
        chk("idle_busy", u_busy, 0);

        // unsigned MAC overflow, four beats of 255*255; sticky ovf
        uq_d.delete(); uq_o.delete();
        for (int k = 0; k < 4; k++) u_beat(2'b10, k == 0, k == 3, 8'd255, 8'd255, 17'd0);
        repeat (5) step();
        chk("mac_ovf_cnt", uq_d.size(), 1);
        chk("mac_ovf_data", uq_at(0), SAT_EN ? 17'd131071 : 17'd129028);
        chk("mac_ovf_flag", uo_at(0), 1);
        // first=1 clears the sticky flag
        uq_d.delete(); uq_o.delete();
        u_beat(2'b10, 1, 1, 8'd1, 8'd1, 17'd0);
        repeat (4) step();
        chk("ovf_clr_data", uq_at(0), 1);
        chk("ovf_clr_flag", uo_at(0), 0);

        // back-pressure: 8 ADD beats, out_ready low for cycles 4..9
        uq_d.delete(); uq_o.delete();
        i = 0; stall_bad = 0; saw_stall = 0; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            u_out_ready = !(cyc >= 4 && cyc <= 9);
            u_in_valid = (i < 8);
            u_op = 2'b00; u_first = 0; u_last = 0; u_act = 8'd1; u_wgt = 8'd0;
            u_addend = UA'(i);
            #1;
            if (u_out_valid && !u_out_ready) begin
                if (!saw_stall) held = u_out_data;
                else if (u_out_data !== held) stall_bad++;
                if (u_in_ready !== 1'b0) stall_bad++;
                saw_stall = 1;
            end
            if (u_in_valid && u_in_ready) i++;
            step();
        end
        u_in_valid = 0; u_out_ready = 1;
        chk("bp_saw_stall", saw_stall, 1);
        chk("bp_stall_hold", stall_bad, 0);
        chk("bp_accepted", i, 8);
        chk("bp_count", uq_d.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_out%0d", k), uq_at(k), UA'(k + 1));

        // ADD/MUL interleaved inside an open MAC sequence
        uq_d.delete(); uq_o.delete();
        u_beat(2'b10, 1, 0, 8'd2, 8'd3, 17'd0);
        u_beat(2'b01, 0, 0, 8'd4, 8'd4, 17'd0);
        u_beat(2'b10, 0, 1, 8'd1, 8'd1, 17'd0);
        repeat (5) step();
        chk("il_count", uq_d.size(), 2);
        chk("il_mul", uq_at(0), 16);
        chk("il_mac", uq_at(1), 7);

        // reset mid-sequence with a result pending and two MAC beats in flight
        u_beat(2'b00, 0, 0, 8'd2, 8'd0, 17'd40);
        u_beat(2'b10, 1, 0, 8'd2, 8'd2, 17'd100);
        u_beat(2'b10, 0, 0, 8'd3, 8'd3, 17'd0);
        chk("pre_rst_valid", u_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", u_out_valid, 0);
        chk("rst_mid_busy", u_busy, 0);
        chk("rst_mid_ready", u_in_ready, 1);
        step();
        rst_n = 1'b1;
        uq_d.delete(); uq_o.delete();
        repeat (4) step();
        chk("rst_no_out", uq_d.size(), 0);
        u_beat(2'b10, 0, 1, 8'd2, 8'd2, 17'd0);
        u_beat(2'b10, 1, 1, 8'd2, 8'd2, 17'd0);
        repeat (4) step();
        chk("post_rst_cnt", uq_d.size(), 2);
        chk("post_rst_acc0", uq_at(0), 4);
        chk("post_rst_mac", uq_at(1), 4);

        // signed MAC: 10 + (-3)*(5+7-2+1) = -23, single output
        sq_d.delete(); sq_o.delete();
        s_beat(2'b10, 1, 0, 8'hFD, 8'd5,  32'd10);
        s_beat(2'b10, 0, 0, 8'hFD, 8'd7,  32'd0);
        s_beat(2'b10, 0, 0, 8'hFD, 8'hFE, 32'd0);
        s_beat(2'b10, 0, 1, 8'hFD, 8'd1,  32'd0);
        repeat (5) step();
        chk("smac_cnt", sq_d.size(), 1);
        e32 = -23;
        chk("smac_data", sq_at(0), e32);
        chk("smac_ovf", so_at(0), 0);

        // signed ADD/MUL boundaries
        sq_d.delete(); sq_o.delete();
        s_beat(2'b00, 0, 0, 8'd1,  8'd0,  32'h7FFF_FFFF);
        s_beat(2'b01, 0, 0, 8'h80, 8'd127, 32'd0);
        s_beat(2'b00, 0, 0, 8'hFF, 8'd0,  32'h8000_0000);
        s_beat(2'b00, 0, 0, 8'hFD, 8'd0,  32'hFFFF_FFFB);
        repeat (5) step();
        chk("sadd_cnt", sq_d.size(), 4);
        chk("sadd_pos_data", sq_at(0), SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000);
        chk("sadd_pos_ovf", so_at(0), 1);
        e32 = -16256;
        chk("smul_data", sq_at(1), e32);
        chk("smul_ovf", so_at(1), 0);
        chk("sadd_neg_data", sq_at(2), SAT_EN ? 32'h8000_0000 : 32'h7FFF_FFFF);
        chk("sadd_neg_ovf", so_at(2), 1);
        e32 = -8;
        chk("sadd_small_data", sq_at(3), e32);
        chk("sadd_small_ovf", so_at(3), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pe.md
Name: dsp_mac_pe

Overview:
- Parametrised, pipelined MAC processing element for the systolic array; next generation of the single-cycle DSP add/MAC wrapper.
- Adds a valid/ready handshake, a fixed 3-stage pipeline, an internal multi-beat accumulator with first/last framing, and signed/unsigned arithmetic.
- Adds overflow detection, with optional saturation.
- Arithmetic is written so synthesis maps the multiply/add onto one DSP48E2 slice.

Parameters:
- ACT_BIT, 8, activation operand width (2..27)
- WEIGHT_BIT, 8, weight operand width (2..18)
- ACCUM_BIT, 32, accumulator/result width (ACT_BIT+WEIGHT_BIT+1..48)
- SIGNED, 0, 1 = two's-complement operands and result, 0 = unsigned

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  PE can accept a beat this cycle
- op  in  2  operation: 00 ADD, 01 MUL, 10 MAC, 11 reserved (treated as ADD)
- first  in  1  MAC only: first beat of a sequence, accumulator is reloaded
- last  in  1  MAC only: final beat, result is emitted
- act  in  ACT_BIT  activation operand
- wgt  in  WEIGHT_BIT  weight operand
- addend  in  ACCUM_BIT  ADD operand / MAC initial bias (used when first=1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACCUM_BIT  result
- out_ovf  out  1  result overflowed (wrapped or clamped)
- busy  out  1  any pipeline stage valid or MAC sequence open

Behaviour:
- Transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - out_data and out_ovf are held stable while out_valid && !out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. All stages freeze on stall; no beat is dropped or duplicated.
- Stage S1 registers act, wgt, addend, op, first, last. Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACCUM_BIT.
- Stage S2 registers product = act*wgt, full width ACT_BIT+WEIGHT_BIT, extended to ACCUM_BIT.
- Stage S3 by operation:
  - ADD: result = addend + ext(act).
  - MUL: result = product.
  - MAC, first=1: acc <= addend + product.
  - MAC, first=0: acc <= acc + product.
- Latency: 3 cycles from accept to out_valid for ADD/MUL and for a MAC beat with last=1. MAC beats with last=0 produce no output.
- Throughput: 1 beat/cycle when not stalled.
- Output values:
  - MAC last beat: out_data = updated acc, and the MAC sequence closes.
  - first=1 && last=1 on one beat is legal (single-beat MAC).
- ADD/MUL beats may interleave inside an open MAC sequence; they neither read nor modify acc.
- MAC with first=0 and no open sequence accumulates onto the current acc (0 after reset).
- first=1 while a sequence is already open restarts it; the open sum is discarded without an output.
- Overflow:
  - An ADD/MUL result that does not fit ACCUM_BIT sets out_ovf for that result.
  - MAC: a sticky ovf flag is set by any wrapping accumulate. It is cleared on first=1 and reported on the last beat.
  - Unsigned overflow = carry out; signed overflow = operand signs equal and result sign differs.
  - Without saturation, results wrap modulo 2^ACCUM_BIT.
- first/last are ignored for ADD/MUL.
- Reset (async assert, sync deassert external): all stage valids 0, acc 0, ovf flag 0, MAC sequence closed. Outputs: out_valid 0, out_data 0, out_ovf 0, in_ready 1, busy 0. Reset mid-sequence abandons in-flight beats with no output.

Optional Feature:
- Macro DSP_MAC_PE_SAT_EN.
- Defined:
  - ADD, MUL and every MAC accumulate step clamp to the ACCUM_BIT range instead of wrapping: unsigned [0, 2^ACCUM_BIT-1]; signed [-2^(ACCUM_BIT-1), 2^(ACCUM_BIT-1)-1].
  - out_ovf still asserts when clamping occurred.
  - A clamped acc stays clamped until first=1.
- Undefined: wrap-around behaviour as above; no clamp logic synthesised.

Test Plan:
- Unsigned MUL: act=200, wgt=250 -> out_valid exactly 3 cycles after accept, out_data=50000, out_ovf=0.
- Signed MAC (SIGNED=1), 4 beats: act=-3 with wgt=5, 7, -2, 1 (first on beat 0, last on beat 3), addend=10 -> single output, out_data=-23; no output after beats 0-2.
- Back-pressure: stream 8 ADD beats (addend=i, act=1) with out_ready low for cycles 4-9 -> in_ready low during the stall, outputs 1..8 in order, none lost or repeated.
- Overflow (ACCUM_BIT=16, unsigned): MAC 255*255 accumulated twice -> out_data=(130050 mod 65536)=64514 with out_ovf=1; with DSP_MAC_PE_SAT_EN, out_data=65535 and out_ovf=1.
- Interleave: open MAC (first, act=2, wgt=3), then MUL 4*4, then MAC (last, act=1, wgt=1) -> MUL output 16 first, then MAC output 7.
- Reset mid-sequence: assert rst_n=0 after 2 MAC beats with 2 beats in flight -> out_valid=0 immediately; after release, single-beat MAC 2*2 with addend 0 -> 4.
